branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped BTB with a 2-bit saturating counter per entry. Consumes the resolved outcome of the branch unit: the branch PC, the actual next PC, and a branch-valid flag.
- Predicts the next PC for fetch in the same cycle.
- Compares the resolved next PC with the next PC predicted earlier and raises a one-cycle registered redirect on mispredict.
- Sits between the branch unit (upstream, update side) and the fetch stage (downstream, predict/redirect side).

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, at least 2.
- IDX_WID, $clog2(ENTRIES), index width; derived, not to be overridden.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_pc  in  32  PC being fetched this cycle.
- pred_hit  out  1  valid entry with matching tag for fetch_pc (combinational).
- pred_taken  out  1  pred_hit and counter[1] (combinational).
- pred_pc  out  32  pred_taken ? stored target : fetch_pc+4 (combinational).
- upd_valid  in  1  branch unit resolved a branch/jump this cycle (branch-valid flag).
- upd_pc  in  32  PC of the resolved instruction.
- upd_next_pc  in  32  actual next PC from the branch unit.
- upd_pred_pc  in  32  next PC that was predicted for this instruction, carried down the pipe.
- upd_is_jump  in  1  unconditional jump.
- redirect_valid  out  1  registered mispredict pulse.
- redirect_pc  out  32  registered correct fetch PC.

Behaviour:
- Address split:
  - idx = pc[IDX_WID+1:2].
  - tag = pc[31:IDX_WID+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target[31:0], ctr[1:0].
  - Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Reset (asynchronous, any time including mid-update):
  - All valid = 0, all ctr = 01, targets = 0.
  - redirect_valid = 0, redirect_pc = 0.
  - pred_hit/pred_taken = 0 and pred_pc = fetch_pc+4 follow from the cleared state.
- Predict path is purely combinational from the table state; zero latency.
- Derived values on update: taken = (upd_next_pc != upd_pc+4); mispredict = upd_valid && (upd_pred_pc != upd_next_pc). All adds are 32-bit modulo; wrap-around at 0xFFFFFFFC is legal.
- Table update on the clk edge when upd_valid = 1:
  - Tag miss or invalid entry: allocate. Set valid, tag, and target = upd_next_pc if taken. Set ctr = 11 if upd_is_jump, else 10 if taken, else 01. An existing entry is overwritten (direct-mapped, no replacement policy).
  - Hit, upd_is_jump: ctr = 11, target = upd_next_pc.
  - Hit, conditional: ctr increments if taken, decrements if not, saturating at 11 and 00. Target is written only when taken.
- Redirect register, updated every edge:
  - redirect_valid <= mispredict.
  - redirect_pc <= upd_next_pc when mispredict, else hold.
  - Exactly one cycle of latency from upd_valid. redirect_valid is never held high for two cycles unless there are back-to-back mispredicts.
- Same-cycle read and write to the same index: prediction uses pre-update contents; no bypass.
- upd_valid = 0: table and redirect_pc unchanged; redirect_valid goes 0 next edge.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Each counter increments on upd_valid and on mispredict respectively, saturating at 0xFFFFFFFF.
  - Both reset to 0 on rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - The counter-state constants (SNT/WNT/WT/ST).
  - A btb_entry_t struct {valid, tag, target, ctr}.
  - A pred_info_t struct {pred_pc} carried through the pipeline to the branch unit.
- One natural sub-module, sat_counter2: pure 2-bit saturating increment/decrement. Table storage and the redirect register stay in branch_predictor.

Test Plan:
- Reset then fetch_pc=0x100 -> pred_hit=0, pred_taken=0, pred_pc=0x104. Assert rst mid-update -> redirect_valid=0 immediately.
- Update upd_pc=0x100, upd_next_pc=0x180, upd_pred_pc=0x104 -> next cycle redirect_valid=1, redirect_pc=0x180. Then fetch 0x100 -> pred_taken=1, pred_pc=0x180 (ctr=10).
- Three not-taken updates at 0x100 (next_pc=0x104) -> ctr 10->01->00->00 saturating; pred_pc=0x104 after the first. redirect_valid=1 only for the update whose upd_pred_pc=0x180.
- Aliasing with ENTRIES=64: train 0x100 taken, then update 0x200 (same idx, different tag) not-taken -> fetch 0x100 misses, pred_pc=0x104.
- Jump at 0x40 to 0x1000 with upd_is_jump=1 -> ctr=11. One not-taken-style update -> still predicts taken (ctr=10).
- BP_STATS_EN: 5 updates with 2 mispredicts -> stat_branches=5, stat_mispredicts=2. Force counter near 0xFFFFFFFF -> holds at max.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor.
// Holds the 2-bit counter state encodings, the BTB entry layout and the
// prediction record carried down the pipe to the branch unit.
package branch_predictor_pkg;

    // 2-bit saturating counter states
    localparam logic [1:0] SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] WT  = 2'b10;  // weak taken
    localparam logic [1:0] ST  = 2'b11;  // strong taken

    // Widest tag any legal ENTRIES (>= 2) can need is 29 bits; the field
    // is sized one wider so narrower tags are always zero-extended.
    localparam int TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    typedef struct packed {
        logic [31:0] pred_pc;
    } pred_info_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: pure combinational 2-bit saturating up/down counter.
// Ports:
//   ctr - current counter value
//   inc - 1 = step toward taken, 0 = step toward not-taken
//   nxt - next counter value, saturating at 11 and 00
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = ctr;
        if (inc) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with a 2-bit counter per entry.
// Predicts the next fetch PC combinationally and raises a registered
// one-cycle redirect when the branch unit reports a mispredicted next PC.
// Optional feature macro: BP_STATS_EN adds branch/mispredict counters.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   fetch_pc          - PC being fetched this cycle
//   pred_hit          - valid entry with matching tag (combinational)
//   pred_taken        - hit and counter predicts taken (combinational)
//   pred_pc           - predicted next PC (combinational)
//   upd_valid         - branch unit resolved a branch/jump this cycle
//   upd_pc            - PC of the resolved instruction
//   upd_next_pc       - actual next PC
//   upd_pred_pc       - next PC predicted earlier for that instruction
//   upd_is_jump       - resolved instruction is an unconditional jump
//   redirect_valid    - registered mispredict pulse
//   redirect_pc       - registered correct fetch PC
//   stat_branches     - (BP_STATS_EN) saturating count of updates
//   stat_mispredicts  - (BP_STATS_EN) saturating count of mispredicts
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_WID = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_next_pc,
    input  logic [31:0] upd_pred_pc,
    input  logic        upd_is_jump,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] pc);
        return TAG_MAX_W'(pc >> (IDX_WID + 2));
    endfunction

    btb_entry_t tbl [ENTRIES];

    // Predict side: reads current table contents, so a same-cycle update
    // to the same index is not visible until the next cycle.
    logic [IDX_WID-1:0] fetch_idx;
    btb_entry_t         fetch_entry;

    always_comb begin
        fetch_idx   = fetch_pc[IDX_WID+1:2];
        fetch_entry = tbl[fetch_idx];
        pred_hit    = fetch_entry.valid && (fetch_entry.tag == tag_of(fetch_pc));
        pred_taken  = pred_hit && fetch_entry.ctr[1];
        pred_pc     = pred_taken ? fetch_entry.target : fetch_pc + 32'd4;
    end

    // Update side
    logic [IDX_WID-1:0] upd_idx;
    btb_entry_t         upd_entry;
    btb_entry_t         new_entry;
    logic               upd_hit;
    logic               taken;
    logic               mispredict;
    logic [1:0]         ctr_step;

    sat_counter2 u_ctr (
        .ctr (upd_entry.ctr),
        .inc (taken),
        .nxt (ctr_step)
    );

    always_comb begin
        upd_idx    = upd_pc[IDX_WID+1:2];
        upd_entry  = tbl[upd_idx];
        upd_hit    = upd_entry.valid && (upd_entry.tag == tag_of(upd_pc));
        taken      = (upd_next_pc != upd_pc + 32'd4);
        mispredict = upd_valid && (upd_pred_pc != upd_next_pc);

        new_entry = upd_entry;
        if (!upd_hit) begin
            // Allocate, overwriting whatever aliased into this slot
            new_entry.valid = 1'b1;
            new_entry.tag   = tag_of(upd_pc);
            if (taken) new_entry.target = upd_next_pc;
            if (upd_is_jump)  new_entry.ctr = ST;
            else if (taken)   new_entry.ctr = WT;
            else              new_entry.ctr = WNT;
        end else if (upd_is_jump) begin
            new_entry.ctr    = ST;
            new_entry.target = upd_next_pc;
        end else begin
            new_entry.ctr = ctr_step;
            if (taken) new_entry.target = upd_next_pc;
        end
    end

    // Table write stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (upd_valid) begin
            tbl[upd_idx] <= new_entry;
        end
    end

    // Redirect register stage: one cycle after the resolving update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) redirect_pc <= upd_next_pc;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES = 64).
// Redirect expectations are pushed to a scoreboard queue when an update
// is driven and popped when the registered redirect appears.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_next_pc;
    logic [31:0] upd_pred_pc;
    logic        upd_is_jump;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    int          exp_branches;
    int          exp_mispredicts;
`endif

    int checks;
    int failures;

    logic [32:0] sb [$];   // {redirect_valid, redirect_pc}
    logic [31:0] model_rpc;

    branch_predictor #(.ENTRIES(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_next_pc    (upd_next_pc),
        .upd_pred_pc    (upd_pred_pc),
        .upd_is_jump    (upd_is_jump),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_redirect(input string tag);
        logic [32:0] e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, redirect_valid}, {31'd0, e[32]});
            chk({tag, "_pc"}, redirect_pc, e[31:0]);
        end
    endtask

    // Drive one resolved update; redirect checked one edge later.
    task automatic upd(input string tag, input logic [31:0] pc, input logic [31:0] nxt,
                       input logic [31:0] prd, input logic jmp);
        logic mis;
        mis = (prd != nxt);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_next_pc = nxt;
        upd_pred_pc = prd;
        upd_is_jump = jmp;
        if (mis) model_rpc = nxt;
        sb.push_back({mis, model_rpc});
`ifdef BP_STATS_EN
        exp_branches++;
        if (mis) exp_mispredicts++;
`endif
        @(posedge clk);
        #1;
        upd_valid   = 1'b0;
        upd_is_jump = 1'b0;
        pop_redirect(tag);
    endtask

    task automatic idle(input string tag);
        sb.push_back({1'b0, model_rpc});
        @(posedge clk);
        #1;
        pop_redirect(tag);
    endtask

    task automatic predict(input string tag, input logic [31:0] pc, input logic hit,
                           input logic tkn, input logic [31:0] npc);
        fetch_pc = pc;
        #1;
        chk({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tkn});
        chk({tag, "_pc"}, pred_pc, npc);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_rpc = 32'd0;
`ifdef BP_STATS_EN
        exp_branches = 0;
        exp_mispredicts = 0;
`endif
        rst = 1'b1;
        fetch_pc = 32'h100;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_next_pc = '0;
        upd_pred_pc = '0;
        upd_is_jump = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        predict("reset_pred", 32'h100, 1'b0, 1'b0, 32'h104);
        chk("reset_rv", {31'd0, redirect_valid}, 32'd0);
        chk("reset_rpc", redirect_pc, 32'd0);

        // Allocate taken, mispredicted
        upd("alloc_taken", 32'h100, 32'h180, 32'h104, 1'b0);
        predict("after_alloc", 32'h100, 1'b1, 1'b1, 32'h180);

        // Not-taken training with saturation at 00
        upd("nt1", 32'h100, 32'h104, 32'h180, 1'b0);
        predict("after_nt1", 32'h100, 1'b1, 1'b0, 32'h104);
        upd("nt2", 32'h100, 32'h104, 32'h104, 1'b0);
        upd("nt3", 32'h100, 32'h104, 32'h104, 1'b0);
        upd("t_from_snt", 32'h100, 32'h180, 32'h104, 1'b0);
        predict("snt_sat", 32'h100, 1'b1, 1'b0, 32'h104);

        // Taken training with saturation at 11
        upd("t2", 32'h100, 32'h180, 32'h104, 1'b0);
        predict("wt", 32'h100, 1'b1, 1'b1, 32'h180);
        upd("t3", 32'h100, 32'h180, 32'h180, 1'b0);
        upd("t4", 32'h100, 32'h180, 32'h180, 1'b0);
        upd("nt_from_st", 32'h100, 32'h104, 32'h180, 1'b0);
        predict("st_sat", 32'h100, 1'b1, 1'b1, 32'h180);

        // Idle: redirect_valid drops, redirect_pc holds
        idle("idle");

        // Aliasing: 0x200 shares index 0 with 0x100
        upd("alias", 32'h200, 32'h204, 32'h204, 1'b0);
        predict("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        predict("alias_new", 32'h200, 1'b1, 1'b0, 32'h204);

        // Jump allocates strong taken
        upd("jump", 32'h40, 32'h1000, 32'h44, 1'b1);
        predict("jump_pred", 32'h40, 1'b1, 1'b1, 32'h1000);
        upd("jump_nt", 32'h40, 32'h44, 32'h1000, 1'b0);
        predict("jump_wt", 32'h40, 1'b1, 1'b1, 32'h1000);

        // Same-cycle read of an index being written sees old contents
        fetch_pc    = 32'h300;
        upd_valid   = 1'b1;
        upd_pc      = 32'h300;
        upd_next_pc = 32'h400;
        upd_pred_pc = 32'h304;
        #1;
        chk("nobypass_hit", {31'd0, pred_hit}, 32'd0);
        chk("nobypass_pc", pred_pc, 32'h304);
        upd("samecyc", 32'h300, 32'h400, 32'h304, 1'b0);
        predict("samecyc_after", 32'h300, 1'b1, 1'b1, 32'h400);

        // Wrap-around: 0xFFFFFFFC + 4 = 0 is not-taken
        upd("wrap", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        predict("wrap_pred", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);

`ifdef BP_STATS_EN
        chk("stat_br", stat_branches, 32'(exp_branches));
        chk("stat_mis", stat_mispredicts, 32'(exp_mispredicts));
`endif

        // Asynchronous reset in the middle of a mispredicting update
        upd_valid   = 1'b1;
        upd_pc      = 32'h100;
        upd_next_pc = 32'h500;
        upd_pred_pc = 32'h104;
        @(posedge clk);
        #3;
        chk("pre_rst_rv", {31'd0, redirect_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_rv", {31'd0, redirect_valid}, 32'd0);
        chk("midrst_rpc", redirect_pc, 32'd0);
        predict("midrst_pred", 32'h300, 1'b0, 1'b0, 32'h304);
        upd_valid = 1'b0;
        sb.delete();
        model_rpc = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
